// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, slice width, width check.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nibble_serial_adder_pkg;

  // Width of one adder slice; the datapath advances by this many bits per clock.
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Legal operand widths: whole slices, and at least two of them so the carry register matters.
  function automatic bit width_ok(input int w);
    return ((w % NIB_W) == 0) && (w >= 2 * NIB_W);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder; ovf exists only with OVERFLOW_FLAG_EN.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cy_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cy_out;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf;
`endif

`ifdef OVERFLOW_FLAG_EN
  // Operand source / result consumer side.
  modport master (
    output in_valid, a, b, cy_in, out_ready,
    input  in_ready, out_valid, sum, cy_out, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cy_in, out_ready,
    output in_ready, out_valid, sum, cy_out, ovf
  );
`else
  // Operand source / result consumer side.
  modport master (
    output in_valid, a, b, cy_in, out_ready,
    input  in_ready, out_valid, sum, cy_out
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cy_in, out_ready,
    output in_ready, out_valid, sum, cy_out
  );
`endif

endinterface

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead adder slice: all four carries from generate/propagate terms.
// Latency: purely combinational.
// Backpressure: none.
module four_bit_carry_look_ahead_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of products so no carry ripples through earlier bits.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s     = p ^ c[3:0];
  assign c_out = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit CLA slice per clock, carry kept in a register; ovf flag with OVERFLOW_FLAG_EN.
// Latency: accept at edge 0, slices at edges 1..NIB, out_valid after edge NIB; one op per NIB+2 cycles.
// Backpressure: result and flags hold in DONE until out_ready; in_ready is high only in IDLE.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (!width_ok(WIDTH)) begin : g_width_chk
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_e             state;
  state_e             state_nxt;
  logic               in_rdy;
  logic               out_vld;

  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   sum_r;
  logic               carry_reg;
  logic [CNT_W-1:0]   cnt;

  logic [NIB_W-1:0]   slice_sum;
  logic               slice_cy;
  logic               accept;
  logic               last_nib;

  assign accept   = bus.in_valid && in_rdy;
  assign last_nib = (cnt == CNT_W'(NIB - 1));

  four_bit_carry_look_ahead_adder u_slice (
    .a     (a_sr[NIB_W-1:0]),
    .b     (b_sr[NIB_W-1:0]),
    .c_in  (carry_reg),
    .s     (slice_sum),
    .c_out (slice_cy)
  );

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs, both decoded from the current state only.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_nib) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_vld = 1'b1;
        if (bus.out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture on accept, then one slice per RUN cycle; sum keeps the last result between ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      sum_r     <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      a_sr      <= bus.a;
      b_sr      <= bus.b;
      carry_reg <= bus.cy_in;
      cnt       <= '0;
    end else if (state == ST_RUN) begin
      sum_r[int'(cnt) * NIB_W +: NIB_W] <= slice_sum;
      carry_reg <= slice_cy;
      a_sr      <= a_sr >> NIB_W;
      b_sr      <= b_sr >> NIB_W;
      cnt       <= cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.sum       = sum_r;
  // The carry register is only meaningful once the last slice has been added.
  assign bus.cy_out    = out_vld & carry_reg;

`ifdef OVERFLOW_FLAG_EN
  logic a_msb;
  logic b_msb;

  // Operand sign bits, kept because the shift registers lose them during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (accept) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end
  end

  // Like-signed operands producing an opposite-signed sum.
  assign bus.ovf = out_vld && (a_msb == b_msb) && (sum_r[WIDTH-1] != a_msb);
`endif

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that feeds one 4-bit slice per clock into a single instance of the team's 4-bit carry-lookahead slice (four_bit_carry_look_ahead_adder).
- Registers the inter-slice carry and assembles the full sum, trading latency for area on FPGA.
- Accepts operands via a valid/ready handshake and returns the sum and carry via a valid/ready handshake.
- Sits between the operand source (register file / test harness) and the result consumer.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 8 (elaboration error otherwise).
- NIB, WIDTH/4, derived localparam: number of slices per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b, cy_in present.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  addend.
- b  input  WIDTH  addend.
- cy_in  input  1  carry into bit 0.
- out_valid  output  1  sum/cy_out valid (high only in DONE).
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result.
- cy_out  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow; present only with OVERFLOW_FLAG_EN.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; in_ready=1; out_valid=0; sum=0; cy_out=0; ovf=0; nibble counter=0; carry register=0; operand shift registers=0. A partial operation is discarded, with no output pulse.
- FSM:
  - IDLE: in_ready=1. When in_valid&&in_ready: latch a, b into shift registers, carry_reg<=cy_in, cnt<=0, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle the slice adds a_sr[3:0], b_sr[3:0] and carry_reg. The 4-bit slice result is written to sum[4*cnt+3:4*cnt], carry_reg<=slice carry, operands shift right 4, cnt++. When cnt==NIB-1, go to DONE.
  - DONE: out_valid=1, cy_out=carry_reg. On out_ready go to IDLE; otherwise hold.
- Latency: accept at edge 0; RUN occupies edges 1..NIB; out_valid rises after edge NIB (4 cycles for WIDTH=16).
- Throughput: one operation per NIB+2 cycles with out_ready tied high.
- Backpressure: sum, cy_out and ovf are stable while out_valid&&!out_ready. Inputs are ignored outside IDLE.
- sum is updated only in RUN. Between operations it holds the last result; it is not cleared on accept.
- Arithmetic is unsigned modulo 2^WIDTH; cy_out is the true carry out. Operands may change after acceptance without effect.
- A simultaneous in_valid in DONE is not accepted (in_ready=0); it must be held until IDLE.

Optional Feature:
- Macro OVERFLOW_FLAG_EN.
- Defined: ovf port exists. In DONE, ovf = (a_msb==b_msb)&&(sum[WIDTH-1]!=a_msb), using latched operand MSBs. ovf is valid with out_valid, stable under backpressure, and 0 on reset.
- Undefined: no ovf port, no MSB latch; the block is otherwise identical.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the nibble width constant NIB_W=4.
- One sub-module: four_bit_carry_look_ahead_adder, instantiated once as the per-cycle slice. Control, counter and shift registers stay in this module.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cy_in=0 -> sum=0x5555, cy_out=0, out_valid exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, cy_in=0 -> sum=0x0000, cy_out=1 (carry ripples through all four slices); a=0x0000, b=0x0000, cy_in=1 -> sum=0x0001, cy_out=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/cy_out constant, in_ready=0. Then out_ready=1 -> IDLE next cycle; a second operation 0x00F0+0x0F10 -> 0x1000.
- Assert rst during RUN cycle 2 of 0x8888+0x8888 -> immediately in_ready=1, out_valid=0, sum=0. A new op 0x0001+0x0001 -> 0x0002.
- OVERFLOW_FLAG_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cy_out=0; 0xFFFF+0x0001 -> ovf=0, cy_out=1.
- Random 1000 operand pairs, random in_valid/out_ready gaps -> sum/cy_out match a+b+cy_in; no accept outside IDLE.
